// File: rtl/sram_arbiter.sv
// Two-port (IF / LS) arbiter for a single-ported SRAM with registered per-port read responses.
// Define SRAM_ARB_RR_EN for round-robin contention; otherwise LS has fixed priority.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Instruction fetch port (read only)
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              if_rsp_ready,
  // Load/store port
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wr_data,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  input  logic              ls_rsp_ready,
  // SRAM port
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wr_data,
  input  logic [DATA_W-1:0] sram_data
);

  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic              ls_rsp_valid_q, ls_rsp_valid_d;
  logic [DATA_W-1:0] if_rsp_data_q, if_rsp_data_d;
  logic [DATA_W-1:0] ls_rsp_data_q, ls_rsp_data_d;

  logic if_slot_free, ls_slot_free;
  logic if_elig, ls_elig, contend;
  logic ls_pri;
  logic grant_if, grant_ls;
  logic rd_if, rd_ls;

  // A slot is free if empty or being drained this cycle.
  assign if_slot_free = !if_rsp_valid_q || if_rsp_ready;
  assign ls_slot_free = !ls_rsp_valid_q || ls_rsp_ready;

  assign if_elig = if_req_valid && if_slot_free;
  assign ls_elig = ls_req_valid && (ls_we || ls_slot_free);
  assign contend = if_elig && ls_elig;

`ifdef SRAM_ARB_RR_EN
  // High when LS won the most recent contended cycle; reset value means IF.
  logic last_ls_q, last_ls_d;

  always_comb begin
    ls_pri    = !last_ls_q;
    last_ls_d = last_ls_q;
    if (contend) begin
      last_ls_d = ls_pri;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls_q <= 1'b0;
    end else begin
      last_ls_q <= last_ls_d;
    end
  end
`else
  assign ls_pri = 1'b1;
`endif

  assign grant_ls = ls_elig && (!if_elig || ls_pri);
  assign grant_if = if_elig && !grant_ls;
  assign rd_if    = grant_if;
  assign rd_ls    = grant_ls && !ls_we;

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  always_comb begin
    sram_en   = rd_if || rd_ls;
    sram_we   = grant_ls && ls_we;
    sram_addr = '0;
    if (grant_ls) begin
      sram_addr = ls_addr;
    end else if (grant_if) begin
      sram_addr = if_addr;
    end
  end

  assign sram_wr_data = ls_wr_data;

  // A new grant into a slot overrides the drain of the previous response.
  always_comb begin
    if_rsp_valid_d = if_rsp_valid_q && !if_rsp_ready;
    if_rsp_data_d  = if_rsp_data_q;
    if (rd_if) begin
      if_rsp_valid_d = 1'b1;
      if_rsp_data_d  = sram_data;
    end
  end

  always_comb begin
    ls_rsp_valid_d = ls_rsp_valid_q && !ls_rsp_ready;
    ls_rsp_data_d  = ls_rsp_data_q;
    if (rd_ls) begin
      ls_rsp_valid_d = 1'b1;
      ls_rsp_data_d  = sram_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      ls_rsp_data_q  <= '0;
    end else begin
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      ls_rsp_data_q  <= ls_rsp_data_d;
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign ls_rsp_data  = ls_rsp_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random traffic against a
// transaction-level model. Expectations follow SRAM_ARB_RR_EN when it is defined.
module tb_sram_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid, ls_rsp_ready;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wr_data, ls_rsp_data;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wr_data, sram_data;

  // Bench-side SRAM: combinational read, posedge write, plus a preload path.
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [0:65535];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (sram_we) mem[sram_addr] <= sram_wr_data;
  end
  assign sram_data = mem[sram_addr];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_ready (if_rsp_ready),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_we        (ls_we),
    .ls_addr      (ls_addr),
    .ls_wr_data   (ls_wr_data),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_data  (ls_rsp_data),
    .ls_rsp_ready (ls_rsp_ready),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wr_data (sram_wr_data),
    .sram_data    (sram_data)
  );

  // Reference model state
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] pre [16];
  logic          m_if_valid, m_ls_valid;
  logic [DW-1:0] m_if_data, m_ls_data;
  logic          m_last_ls;  // last contended cycle went to LS
  int            last_win;   // 0 none, 1 IF, 2 LS
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_if_valid = 1'b0;
    m_ls_valid = 1'b0;
    m_if_data  = '0;
    m_ls_data  = '0;
    m_last_ls  = 1'b0;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_addr = '0; if_rsp_ready = 1'b1;
    ls_req_valid = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wr_data = '0; ls_rsp_ready = 1'b1;
  endtask

  // One clock cycle: check combinational grant/SRAM drive, clock, then check response slots.
  task automatic cycle(input string tag);
    logic if_ok, ls_ok, exp_en, exp_we;
    logic [AW-1:0] exp_addr;
    int win;
    #1;
    if_ok = if_req_valid && (!m_if_valid || if_rsp_ready);
    ls_ok = ls_req_valid && (ls_we || !m_ls_valid || ls_rsp_ready);
    win = 0;
    if (if_ok && ls_ok) begin
`ifdef SRAM_ARB_RR_EN
      win = m_last_ls ? 1 : 2;
      m_last_ls = (win == 2);
`else
      win = 2;
`endif
    end else if (if_ok) win = 1;
    else if (ls_ok) win = 2;
    last_win = win;
    exp_en   = (win == 1) || (win == 2 && !ls_we);
    exp_we   = (win == 2) && ls_we;
    exp_addr = (win == 1) ? if_addr : (win == 2) ? ls_addr : '0;
    chk({tag, ".if_req_ready"}, 32'(if_req_ready), 32'(win == 1));
    chk({tag, ".ls_req_ready"}, 32'(ls_req_ready), 32'(win == 2));
    chk({tag, ".sram_en"}, 32'(sram_en), 32'(exp_en));
    chk({tag, ".sram_we"}, 32'(sram_we), 32'(exp_we));
    chk({tag, ".sram_addr"}, 32'(sram_addr), 32'(exp_addr));
    chk({tag, ".sram_wr_data"}, sram_wr_data, ls_wr_data);
    @(posedge clk);
    if (if_rsp_ready) m_if_valid = 1'b0;
    if (ls_rsp_ready) m_ls_valid = 1'b0;
    if (win == 1) begin
      m_if_valid = 1'b1;
      m_if_data  = ref_mem[if_addr];
    end else if (win == 2 && !ls_we) begin
      m_ls_valid = 1'b1;
      m_ls_data  = ref_mem[ls_addr];
    end else if (win == 2) begin
      ref_mem[ls_addr] = ls_wr_data;
    end
    #1;
    chk({tag, ".if_rsp_valid"}, 32'(if_rsp_valid), 32'(m_if_valid));
    chk({tag, ".if_rsp_data"}, if_rsp_data, m_if_data);
    chk({tag, ".ls_rsp_valid"}, 32'(ls_rsp_valid), 32'(m_ls_valid));
    chk({tag, ".ls_rsp_data"}, ls_rsp_data, m_ls_data);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  initial begin
    logic exp_ls;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    idle_inputs();
    model_reset();
    last_win = 0;
    rst_n = 1'b0;
    #1;
    chk("reset.if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    chk("reset.ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);
    chk("reset.if_rsp_data", if_rsp_data, 32'd0);
    chk("reset.ls_rsp_data", ls_rsp_data, 32'd0);
    chk("reset.sram_en", 32'(sram_en), 32'd0);
    chk("reset.sram_addr", 32'(sram_addr), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      pre[i] = $urandom;
      preload(AW'(i), pre[i]);
    end
    preload(16'h0010, 32'hDEADBEEF);

    // IF read alone
    if_req_valid = 1'b1; if_addr = 16'h0010;
    cycle("if_read");
    chk("if_read.data", if_rsp_data, 32'hDEADBEEF);
    chk("if_read.valid", 32'(if_rsp_valid), 32'd1);
    if_req_valid = 1'b0;

    // LS write then read back
    ls_req_valid = 1'b1; ls_we = 1'b1; ls_addr = 16'h0100; ls_wr_data = 32'hCAFEF00D;
    cycle("ls_write");
    chk("ls_write.no_rsp", 32'(ls_rsp_valid), 32'd0);
    ls_we = 1'b0; ls_wr_data = 32'h0;
    cycle("ls_read");
    chk("ls_read.data", ls_rsp_data, 32'hCAFEF00D);
    ls_req_valid = 1'b0;
    cycle("drain");

    // Four contended cycles; no contention has occurred since reset
    if_req_valid = 1'b1; if_addr = 16'd5;
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 16'd9;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      exp_ls = (i % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      #1;
      chk("contend.ls_grant", 32'(ls_req_ready), 32'(exp_ls));
      chk("contend.if_grant", 32'(if_req_ready), 32'(!exp_ls));
      cycle("contend");
    end
    ls_req_valid = 1'b0;
    cycle("contend_tail");
    if_req_valid = 1'b0;
    cycle("drain2");

    // Backpressure on IF
    if_req_valid = 1'b1; if_addr = 16'd1;
    cycle("bp_first");
    if_addr = 16'd2; if_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.blocked", 32'(if_req_ready), 32'd0);
      cycle("bp_hold");
      chk("bp.held_data", if_rsp_data, pre[1]);
    end
    if_rsp_ready = 1'b1;
    #1;
    chk("bp.release_grant", 32'(if_req_ready), 32'd1);
    cycle("bp_release");
    chk("bp.new_data", if_rsp_data, pre[2]);
    if_req_valid = 1'b0;

    // Random traffic; requests hold their fields until granted
    for (int i = 0; i < 400; i++) begin
      if (!if_req_valid || last_win == 1) begin
        if_req_valid = 1'($urandom_range(0, 1));
        if_addr      = AW'($urandom_range(0, 15));
      end
      if (!ls_req_valid || last_win == 2) begin
        ls_req_valid = 1'($urandom_range(0, 1));
        ls_we        = 1'($urandom_range(0, 1));
        ls_addr      = AW'($urandom_range(0, 15));
        ls_wr_data   = $urandom;
      end
      if_rsp_ready = ($urandom_range(0, 3) != 0);
      ls_rsp_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    // Asynchronous reset with a pending LS response
    idle_inputs();
    cycle("pre_rst_drain");
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 16'd3; ls_rsp_ready = 1'b0;
    cycle("pre_rst_read");
    chk("pre_rst.ls_valid", 32'(ls_rsp_valid), 32'd1);
    ls_req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);
    chk("async_rst.ls_rsp_data", ls_rsp_data, 32'd0);
    chk("async_rst.if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    ls_rsp_ready = 1'b1;
    if_req_valid = 1'b1; if_addr = 16'd4;
    ls_req_valid = 1'b1; ls_addr = 16'd6;
    cycle("post_rst_contend");
    idle_inputs();
    cycle("post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter sharing the single-ported `sram` between the instruction-fetch (IF) and load/store (LS) requesters of the core. It accepts at most one access per cycle and drives the SRAM's combinational-read/posedge-write port. It registers read data into a per-port response slot with valid/ready backpressure. The block sits between the pipeline front-end/LSU and the memory instance.

## Interface
- `ADDR_W`, 16, address width; matches the sram `addr_width`.
- `DATA_W`, 32, data width; matches the sram `data_width`.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req_valid` in 1: IF read request.
- `if_req_ready` out 1: IF request granted this cycle.
- `if_addr` in ADDR_W: IF read address.
- `if_rsp_valid` out 1: IF response slot holds data.
- `if_rsp_data` out DATA_W: IF read data.
- `if_rsp_ready` in 1: IF consumes the response.
- `ls_req_valid` in 1: LS request.
- `ls_req_ready` out 1: LS request granted this cycle.
- `ls_we` in 1: 1 = write, 0 = read.
- `ls_addr` in ADDR_W: LS address.
- `ls_wr_data` in DATA_W: LS write data.
- `ls_rsp_valid` out 1: LS read response slot holds data. Reads only.
- `ls_rsp_data` out DATA_W: LS read data.
- `ls_rsp_ready` in 1: LS consumes the response.
- `sram_en` out 1: to sram `en`.
- `sram_we` out 1: to sram `we`.
- `sram_addr` out ADDR_W: to sram `addr`.
- `sram_wr_data` out DATA_W: to sram `wr_data`.
- `sram_data` in DATA_W: from sram `data`.

## Operation
- **Slot free (per port):** `rsp_valid==0`, or `rsp_valid && rsp_ready` in the same cycle.
- **Eligibility:**
  - IF is eligible when `if_req_valid` is high and its slot is free.
  - An LS write is eligible whenever `ls_req_valid` is high; it needs no slot.
  - An LS read is eligible when `ls_req_valid` is high and the LS slot is free.
- **Arbitration:**
  - Combinational, same cycle. Exactly one eligible port is granted; `req_ready` is high only for the winner.
  - A non-eligible requester sees `req_ready=0`.
  - Requesters hold request fields stable until `req_valid && req_ready`.
- **Contention (both eligible):** resolved per Configuration. A lone eligible port is always granted.
- **SRAM drive:**
  - Driven from the winner: `sram_addr` = winner address; `sram_we` = `ls_we` if LS wins, else 0.
  - `sram_en` = 1 for a granted read, 0 otherwise.
  - `sram_wr_data` = `ls_wr_data` unconditionally.
  - With no grant: `sram_en=0`, `sram_we=0`, `sram_addr=0`.
- **Response capture:**
  - On a granted read, `sram_data` is registered into the winner's `rsp_data` at the closing clock edge, and its `rsp_valid` sets.
  - `rsp_valid` clears on `rsp_valid && rsp_ready` unless a new read into the same slot is granted that cycle. In that case it stays 1 with the new data.
  - `rsp_data` holds its value while `rsp_valid` is high and `rsp_ready` is low.
- **Ordering:** per-port responses return in request order; at most one outstanding per port.
- **Reset values:**
  - `if_rsp_valid=0`, `ls_rsp_valid=0`, `if_rsp_data=0`, `ls_rsp_data=0`.
  - Last-grant register = IF.
  - Combinational outputs follow inputs.
- **Reset mid-operation:** pending responses are discarded immediately. A write granted in the cycle reset asserts is not guaranteed.

## Timing
- Read: grant in cycle N; `rsp_valid` high from cycle N+1 with data = `memory[addr]` as sampled at the end of cycle N.
- Write: grant in cycle N; the SRAM updates at the end of cycle N. An LS read of the same address granted in cycle N+1 returns the new data.
- Throughput: one access per cycle total. A port whose consumer holds `rsp_ready=1` can read every cycle.
- Back-to-back on one port with `rsp_ready=1`: `rsp_valid` stays high and the data updates each cycle.
- Read-after-read from different ports in consecutive cycles: no bubble.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin.
  - On contention, the port not granted in the most recent contended cycle wins; the last-grant register updates only on contended cycles.
  - After reset, the first contention goes to LS.
- `SRAM_ARB_RR_EN` undefined: fixed priority, LS always wins contention. IF can be starved indefinitely; the last-grant register is unused.

## Test plan
- **IF read alone:** preload mem[0x0010]=0xDEADBEEF; IF reads 0x0010 in cycle 1 → `if_req_ready`=1 in cycle 1, `if_rsp_valid`=1 and data=0xDEADBEEF in cycle 2.
- **LS write then LS read:** write 0xCAFEF00D to 0x0100 in cycle N, read 0x0100 in cycle N+1 → `ls_rsp_data`=0xCAFEF00D in cycle N+2; `ls_rsp_valid` never set by the write.
- **Contention for 4 cycles, fixed priority (macro undefined):** LS always granted, IF `req_ready`=0 throughout.
- **Contention for 4 cycles, `SRAM_ARB_RR_EN` defined:** grants alternate LS, IF, LS, IF.
- **Backpressure:** IF read granted, then `if_rsp_ready`=0 for 3 cycles with `if_req_valid`=1 → `if_req_ready`=0, data held. Raise `if_rsp_ready` → grant in that same cycle, new data the next cycle.
- **Reset:** assert `rst_n`=0 asynchronously while `ls_rsp_valid`=1 → `ls_rsp_valid`=0 and `ls_rsp_data`=0 immediately, without waiting for a clock edge.
